// File: rtl/tetris_pkg.sv
// Shared Tetris constants: board geometry, row-clear FSM encoding and the line-clear score table
// (also used by the LCD formatter).
package tetris_pkg;

  localparam int unsigned BOARD_ROWS = 24;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned SCORE_W    = 7;
  localparam int unsigned SCORE_MAX  = 99;
  localparam int unsigned INC_W      = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } rc_state_e;

  // Points for a single pass; anything beyond a four-line clear scores like one.
  function automatic logic [INC_W-1:0] score_inc(input logic [ADDR_W-1:0] lines);
    logic [INC_W-1:0] inc;
    case (lines)
      5'd0:    inc = 4'd0;
      5'd1:    inc = 4'd1;
      5'd2:    inc = 4'd3;
      5'd3:    inc = 4'd5;
      default: inc = 4'd8;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/tetris_row_clear_if.sv
// Control, board row port and status bundle of the row-clear engine.
// slave = the engine, master = the top level owning the board array.
interface tetris_row_clear_if;
  import tetris_pkg::*;

  logic                  start;
  logic                  score_clr;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     rd_addr;
  logic [BOARD_COLS-1:0] rd_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [BOARD_COLS-1:0] wr_data;
  logic [ADDR_W-1:0]     lines_cleared;
  logic [SCORE_W-1:0]    score;

  modport master (
    output start, score_clr, rd_data,
    input  busy, done, rd_addr, wr_en, wr_addr, wr_data, lines_cleared, score
  );

  modport slave (
    input  start, score_clr, rd_data,
    output busy, done, rd_addr, wr_en, wr_addr, wr_data, lines_cleared, score
  );

endinterface

// File: rtl/tetris_score_acc.sv
// Saturating score accumulator: adds the table value for a pass's line count on upd;
// a synchronous clear takes priority over a coinciding update.
module tetris_score_acc import tetris_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               upd,
  input  logic [ADDR_W-1:0]  lines,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W:0] SatLimit = (SCORE_W + 1)'(SCORE_MAX);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;

  always_comb begin
    sum     = {1'b0, score_q} + {{(SCORE_W + 1 - INC_W){1'b0}}, score_inc(lines)};
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (upd) begin
      score_d = (sum > SatLimit) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/tetris_row_clear.sv
// Line-clear engine: scans the board bottom-up, drops surviving rows over full ones,
// zero-fills the vacated top rows and reports the lines removed plus a saturating score.
module tetris_row_clear import tetris_pkg::*; (
  input logic              clk,
  input logic              rst,
  tetris_row_clear_if.slave bus
);

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(BOARD_ROWS - 1);

  rc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, wr_ptr_q, cnt_q, lines_q;
  logic              busy_q, done_q;
  logic              row_full, last_row, enter_done;
  logic [ADDR_W-1:0] cnt_scan, cnt_final;

  assign row_full = &bus.rd_data;
  assign last_row = (rd_ptr_q == '0);

  always_comb begin
    cnt_scan  = cnt_q + ADDR_W'(row_full);
    cnt_final = (state_q == StScan) ? cnt_scan : cnt_q;
    state_d   = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StScan;
      StScan:  if (last_row) state_d = (cnt_scan != '0) ? StFill : StDone;
      StFill:  if (wr_ptr_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    enter_done = (state_d == StDone);
  end

  // The write port is combinational: a surviving row is rewritten in the same cycle it is read,
  // always at or below its old position, so it never overwrites an unread row.
  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    if (state_q == StScan && !row_full && cnt_q != '0) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = wr_ptr_q;
      bus.wr_data = bus.rd_data;
    end else if (state_q == StFill) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      lines_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= enter_done;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            rd_ptr_q <= LastRow;
            wr_ptr_q <= LastRow;
            cnt_q    <= '0;
          end
        end
        StScan: begin
          if (row_full) begin
            cnt_q <= cnt_scan;
          end else if (wr_ptr_q != '0) begin
            wr_ptr_q <= wr_ptr_q - 1'b1;
          end
          // rd_ptr parks at row 0 so rd_addr holds its last value outside the scan.
          if (!last_row) rd_ptr_q <= rd_ptr_q - 1'b1;
        end
        StFill: begin
          if (wr_ptr_q != '0) wr_ptr_q <= wr_ptr_q - 1'b1;
        end
        default: ;
      endcase
      if (enter_done) lines_q <= cnt_final;
    end
  end

  tetris_score_acc u_score_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.score_clr),
    .upd   (enter_done),
    .lines (cnt_final),
    .score (bus.score)
  );

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rd_addr       = rd_ptr_q;
  assign bus.lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_row_clear.sv
// Bench for tetris_row_clear: owns the board array, drives passes and compares against
// hand-computed results and a gravity-compaction reference model.
module tb_tetris_row_clear;
  import tetris_pkg::*;

  localparam int ROWS = BOARD_ROWS;
  typedef logic [BOARD_COLS-1:0] row_t;
  typedef row_t board_t [BOARD_ROWS];
  localparam row_t FULL = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tetris_row_clear_if bus ();
  tetris_row_clear dut (.clk(clk), .rst(rst), .bus(bus));

  row_t board [BOARD_ROWS];
  assign bus.rd_data = board[bus.rd_addr];

  int checks = 0;
  int failures = 0;
  int score_ref = 0;

  // Observations of the last pass.
  int dc, dn, wc, pb;
  logic [4:0] lc;
  logic [6:0] sc;

  board_t exp_b;
  int n;

  function automatic void model_clear(input board_t b, output board_t e, output int cleared);
    row_t survivors[$];
    cleared = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r] == FULL) cleared++;
      else survivors.push_back(b[r]);
    end
    for (int r = 0; r < ROWS; r++) e[r] = '0;
    for (int i = 0; i < survivors.size(); i++) e[ROWS - 1 - i] = survivors[i];
  endfunction

  function automatic int score_after(input int s, input int lines);
    int tbl[6] = '{0, 1, 3, 5, 8, 8};
    int t;
    t = s + tbl[(lines > 5) ? 5 : lines];
    return (t > 99) ? 99 : t;
  endfunction

  function automatic int board_diff(input board_t e);
    int d = 0;
    for (int r = 0; r < ROWS; r++) if (board[r] !== e[r]) d++;
    return d;
  endfunction

  function automatic board_t cur_board();
    board_t b;
    for (int r = 0; r < ROWS; r++) b[r] = board[r];
    return b;
  endfunction

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) board[r] = '0;
  endtask

  task automatic bottom_full(input int k);
    clear_board();
    for (int r = ROWS - k; r < ROWS; r++) board[r] = FULL;
  endtask

  // Runs one pass starting at cycle 0; applies board writes and records protocol violations.
  task automatic run_pass(input int clr_at, input int restart_at);
    bit pw;
    logic [4:0] pa;
    row_t pd;
    bit exp_busy;
    dc = -1; dn = 0; wc = 0; pb = 0; lc = 'x; sc = 'x;
    @(negedge clk);
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.start = (cyc == 0) || (cyc == restart_at);
      bus.score_clr = (cyc == clr_at);
      if (bus.done === 1'b1) begin
        dn++;
        if (dc < 0) begin dc = cyc; lc = bus.lines_cleared; sc = bus.score; end
      end
      exp_busy = (cyc >= 1) && (dc < 0 || cyc == dc);
      if (bus.busy !== exp_busy) pb++;
      if (cyc >= 1 && cyc <= ROWS && bus.rd_addr !== 5'(ROWS - cyc)) pb++;
      pw = (bus.wr_en === 1'b1);
      pa = bus.wr_addr;
      pd = bus.wr_data;
      if (pw) begin
        wc++;
        if (pa < bus.rd_addr || pa >= 5'(ROWS) || cyc == 0 || dc >= 0) pb++;
      end
      if (dc >= 0 && cyc >= dc + 20) break;
      @(posedge clk);
      #1;
      if (pw && pa < 5'(ROWS)) board[pa] = pd;
    end
    bus.start = 1'b0;
    bus.score_clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got busy/done/wr_en=%b want 000", {bus.busy, bus.done, bus.wr_en});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.lines_cleared, bus.score} !== '0) begin
      failures++;
      $display("FAIL reset_data got rd=%0d wa=%0d wd=%h lc=%0d sc=%0d want all 0",
               bus.rd_addr, bus.wr_addr, bus.wr_data, bus.lines_cleared, bus.score);
    end
    rst = 1'b1;
  endtask

  task automatic test_empty();
    clear_board();
    run_pass(-1, -1);
    checks++; if (dc !== 25) begin failures++; $display("FAIL empty_done got %0d want 25", dc); end
    checks++; if (wc !== 0) begin failures++; $display("FAIL empty_writes got %0d want 0", wc); end
    checks++; if (lc !== 5'd0) begin failures++; $display("FAIL empty_lines got %0d want 0", lc); end
    checks++;
    if (sc !== 7'(score_ref)) begin failures++; $display("FAIL empty_score got %0d want %0d", sc, score_ref); end
    checks++; if (pb !== 0 || dn !== 1) begin failures++; $display("FAIL empty_proto got bad=%0d dones=%0d want 0/1", pb, dn); end
  endtask

  task automatic test_two_rows();
    clear_board();
    board[23] = FULL; board[22] = 10'h155; board[21] = FULL; board[20] = 10'h0F0;
    for (int r = 0; r < ROWS; r++) exp_b[r] = '0;
    exp_b[23] = 10'h155; exp_b[22] = 10'h0F0;
    run_pass(-1, -1);
    score_ref = score_ref + 3;
    checks++; if (dc !== 27) begin failures++; $display("FAIL two_done got %0d want 27", dc); end
    checks++; if (lc !== 5'd2) begin failures++; $display("FAIL two_lines got %0d want 2", lc); end
    checks++;
    if (sc !== 7'(score_ref)) begin failures++; $display("FAIL two_score got %0d want %0d", sc, score_ref); end
    checks++;
    if (board_diff(exp_b) !== 0) begin failures++; $display("FAIL two_board got %0d bad rows want 0", board_diff(exp_b)); end
    checks++; if (pb !== 0) begin failures++; $display("FAIL two_proto got %0d want 0", pb); end
  endtask

  task automatic test_four_rows();
    bottom_full(4);
    board[19] = 10'h201;
    for (int r = 0; r < ROWS; r++) exp_b[r] = '0;
    exp_b[23] = 10'h201;
    run_pass(-1, -1);
    score_ref = score_ref + 8;
    checks++; if (dc !== 29) begin failures++; $display("FAIL four_done got %0d want 29", dc); end
    checks++; if (lc !== 5'd4) begin failures++; $display("FAIL four_lines got %0d want 4", lc); end
    checks++;
    if (sc !== 7'(score_ref)) begin failures++; $display("FAIL four_score got %0d want %0d", sc, score_ref); end
    checks++;
    if (board_diff(exp_b) !== 0) begin failures++; $display("FAIL four_board got %0d bad rows want 0", board_diff(exp_b)); end
  endtask

  task automatic test_all_full();
    bottom_full(ROWS);
    for (int r = 0; r < ROWS; r++) exp_b[r] = '0;
    run_pass(-1, -1);
    score_ref = score_after(score_ref, 24);
    checks++; if (dc !== 49) begin failures++; $display("FAIL full_done got %0d want 49", dc); end
    checks++; if (wc !== 24) begin failures++; $display("FAIL full_writes got %0d want 24", wc); end
    checks++; if (lc !== 5'd24) begin failures++; $display("FAIL full_lines got %0d want 24", lc); end
    checks++;
    if (sc !== 7'(score_ref)) begin failures++; $display("FAIL full_score got %0d want %0d", sc, score_ref); end
    checks++;
    if (board_diff(exp_b) !== 0) begin failures++; $display("FAIL full_board got %0d bad rows want 0", board_diff(exp_b)); end
  endtask

  task automatic test_saturation();
    int steps[3] = '{2, 1, 4};
    int want[3] = '{98, 99, 99};
    @(negedge clk);
    bus.score_clr = 1'b1;
    @(negedge clk);
    bus.score_clr = 1'b0;
    checks++; if (bus.score !== 7'd0) begin failures++; $display("FAIL idle_clr got %0d want 0", bus.score); end
    score_ref = 0;
    // 11 x 8 + 3 + 3 + 1 = 95
    for (int i = 0; i < 14; i++) begin
      bottom_full((i < 11) ? 4 : (i < 13) ? 2 : 1);
      run_pass(-1, -1);
    end
    checks++; if (sc !== 7'd95) begin failures++; $display("FAIL preload_score got %0d want 95", sc); end
    for (int i = 0; i < 3; i++) begin
      bottom_full(steps[i]);
      run_pass(-1, -1);
      checks++;
      if (sc !== 7'(want[i])) begin failures++; $display("FAIL sat_score step %0d got %0d want %0d", i, sc, want[i]); end
    end
    bottom_full(2);
    run_pass(ROWS + 2, -1);
    score_ref = 0;
    checks++; if (sc !== 7'd0) begin failures++; $display("FAIL clr_wins got %0d want 0", sc); end
    checks++; if (lc !== 5'd2 || dc !== 27) begin failures++; $display("FAIL clr_pass got lines=%0d done=%0d want 2/27", lc, dc); end
  endtask

  task automatic load_random();
    for (int r = 0; r < ROWS; r++) board[r] = ($urandom_range(0, 2) == 0) ? FULL : row_t'($urandom);
  endtask

  task automatic test_random();
    int exp_s;
    for (int it = 0; it < 10; it++) begin
      load_random();
      model_clear(cur_board(), exp_b, n);
      exp_s = score_after(score_ref, n);
      run_pass(-1, -1);
      score_ref = exp_s;
      checks++;
      if (dc !== ROWS + n + 1) begin failures++; $display("FAIL rnd%0d_done got %0d want %0d", it, dc, ROWS + n + 1); end
      checks++; if (lc !== 5'(n)) begin failures++; $display("FAIL rnd%0d_lines got %0d want %0d", it, lc, n); end
      checks++;
      if (sc !== 7'(exp_s)) begin failures++; $display("FAIL rnd%0d_score got %0d want %0d", it, sc, exp_s); end
      checks++;
      if (board_diff(exp_b) !== 0) begin failures++; $display("FAIL rnd%0d_board got %0d bad rows want 0", it, board_diff(exp_b)); end
      checks++; if (pb !== 0) begin failures++; $display("FAIL rnd%0d_proto got %0d want 0", it, pb); end
    end
  endtask

  task automatic test_back_to_back_start();
    int exp_s;
    load_random();
    board[23] = FULL;
    model_clear(cur_board(), exp_b, n);
    exp_s = score_after(score_ref, n);
    run_pass(-1, 5);
    score_ref = exp_s;
    checks++; if (dn !== 1) begin failures++; $display("FAIL restart_dones got %0d want 1", dn); end
    checks++;
    if (dc !== ROWS + n + 1) begin failures++; $display("FAIL restart_done got %0d want %0d", dc, ROWS + n + 1); end
    checks++;
    if (board_diff(exp_b) !== 0 || sc !== 7'(exp_s)) begin
      failures++; $display("FAIL restart_result got bad_rows=%0d score=%0d want 0/%0d", board_diff(exp_b), sc, exp_s);
    end
    checks++; if (pb !== 0) begin failures++; $display("FAIL restart_proto got %0d want 0", pb); end
  endtask

  task automatic test_reset_mid_scan();
    int exp_s;
    bottom_full(3);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wr_en} !== 3'b000) begin
      failures++; $display("FAIL midrst_ctrl got busy/done/wr_en=%b want 000", {bus.busy, bus.done, bus.wr_en});
    end
    checks++;
    if ({bus.rd_addr, bus.wr_addr, bus.wr_data, bus.lines_cleared, bus.score} !== '0) begin
      failures++;
      $display("FAIL midrst_data got rd=%0d wa=%0d wd=%h lc=%0d sc=%0d want all 0",
               bus.rd_addr, bus.wr_addr, bus.wr_data, bus.lines_cleared, bus.score);
    end
    @(negedge clk);
    rst = 1'b1;
    score_ref = 0;
    load_random();
    model_clear(cur_board(), exp_b, n);
    exp_s = score_after(0, n);
    run_pass(-1, -1);
    checks++;
    if (dc !== ROWS + n + 1 || lc !== 5'(n)) begin
      failures++; $display("FAIL postrst_pass got done=%0d lines=%0d want %0d/%0d", dc, lc, ROWS + n + 1, n);
    end
    checks++;
    if (board_diff(exp_b) !== 0 || sc !== 7'(exp_s)) begin
      failures++; $display("FAIL postrst_result got bad_rows=%0d score=%0d want 0/%0d", board_diff(exp_b), sc, exp_s);
    end
    score_ref = exp_s;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.score_clr = 1'b0;
    clear_board();
    test_reset();
    test_empty();
    test_two_rows();
    test_four_rows();
    test_all_full();
    test_saturation();
    test_random();
    test_back_to_back_start();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
